// File: rtl/ppfifo_2_mem_pkg.sv
// Shared definitions for the ping-pong FIFO to memory Wishbone master.
// Contents: FSM state encoding, default buffer base addresses, full byte-lane
// select value and the buffer selection helper.
package ppfifo_2_mem_pkg;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_ACTIVATE = 4'd1,
        ST_WRITE    = 4'd2,
        ST_WAIT_ACK = 4'd3,
        ST_NEXT     = 4'd4,
        ST_RELEASE  = 4'd5
    } state_e;

    localparam logic [31:0] DEFAULT_MEM_0_BASE_C = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_MEM_1_BASE_C = 32'h0010_0000;
    localparam logic [3:0]  SEL_ALL              = 4'hF;

    // Preferred buffer if it is armed, otherwise the other one.
    function automatic logic pick_buf(input logic nxt, input logic empty_0, input logic empty_1);
        logic nxt_empty;
        nxt_empty = nxt ? empty_1 : empty_0;
        return nxt_empty ? ~nxt : nxt;
    endfunction

endpackage

// File: rtl/ppfifo_2_mem_buf_ctrl.sv
// Per-buffer bookkeeping: latches base/size on an arm pulse, counts words
// written and raises a one-cycle finished pulse when the buffer fills.
// Ports:
//   clk, rst      : clock, async active-high reset
//   i_base/i_size : host-supplied base address and size (words)
//   i_ready       : arm pulse, honoured only while empty and size != 0
//   i_inc         : one word has been written into this buffer
//   o_base/o_size : latched base/size
//   o_count       : words written since the last arm
//   o_empty       : buffer not armed
//   o_finished    : one-cycle pulse on the word that fills the buffer
module ppfifo_2_mem_buf_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] i_base,
    input  logic [31:0] i_size,
    input  logic        i_ready,
    input  logic        i_inc,
    output logic [31:0] o_base,
    output logic [31:0] o_size,
    output logic [31:0] o_count,
    output logic        o_empty,
    output logic        o_finished
);

    logic [31:0] base_q, base_d;
    logic [31:0] size_q, size_d;
    logic [31:0] count_q, count_d;
    logic        empty_q, empty_d;
    logic        finished_q, finished_d;

    always_comb begin
        base_d     = base_q;
        size_d     = size_q;
        count_d    = count_q;
        empty_d    = empty_q;
        finished_d = 1'b0;
        // A write takes priority; an arm in the same cycle is dropped because
        // the buffer is still marked busy.
        if (i_inc) begin
            count_d = count_q + 32'd1;
            if (count_d == size_q) begin
                empty_d    = 1'b1;
                finished_d = 1'b1;
            end
        end else if (i_ready && empty_q && (i_size != 32'd0)) begin
            base_d  = i_base;
            size_d  = i_size;
            count_d = 32'd0;
            empty_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            base_q     <= 32'd0;
            size_q     <= 32'd0;
            count_q    <= 32'd0;
            empty_q    <= 1'b1;
            finished_q <= 1'b0;
        end else begin
            base_q     <= base_d;
            size_q     <= size_d;
            count_q    <= count_d;
            empty_q    <= empty_d;
            finished_q <= finished_d;
        end
    end

    assign o_base     = base_q;
    assign o_size     = size_q;
    assign o_count    = count_q;
    assign o_empty    = empty_q;
    assign o_finished = finished_q;

endmodule

// File: rtl/wb_ppfifo_to_mem.sv
// Wishbone master draining a ping-pong FIFO read port into two host-armed
// memory buffers, alternating between them and spilling mid-block into the
// other buffer when one fills.
// Ports: clk/rst (async active-high), debug bus, host buffer config and
// status (base/size/ready in; count/finished/empty out), Wishbone master
// (o_mem_*, i_mem_*), ping-pong FIFO read side (i_ppfifo_*, o_ppfifo_*).
// Build option: PPFIFO_2_MEM_DEBUG_EN exposes FSM state on debug, else 0.
//
// state    | meaning
// IDLE     | waiting for enable, a ready FIFO block and an armed buffer
// ACTIVATE | block taken (act high), block size latched
// WRITE    | present address/data of the current word on the bus
// WAIT_ACK | strobe high until ack, then pop the FIFO word
// NEXT     | pick buffer for next word, stall here if none armed
// RELEASE  | act and cyc dropped, one cycle before IDLE
module wb_ppfifo_to_mem
    import ppfifo_2_mem_pkg::*;
#(
    parameter logic [31:0] DEFAULT_MEM_0_BASE = DEFAULT_MEM_0_BASE_C,
    parameter logic [31:0] DEFAULT_MEM_1_BASE = DEFAULT_MEM_1_BASE_C
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] debug,
    input  logic        i_enable,
    input  logic [31:0] i_memory_0_base,
    input  logic [31:0] i_memory_0_size,
    output logic [31:0] o_memory_0_count,
    input  logic        i_memory_0_ready,
    output logic        o_memory_0_finished,
    output logic        o_memory_0_empty,
    output logic [31:0] o_default_mem_0_base,
    input  logic [31:0] i_memory_1_base,
    input  logic [31:0] i_memory_1_size,
    output logic [31:0] o_memory_1_count,
    input  logic        i_memory_1_ready,
    output logic        o_memory_1_finished,
    output logic        o_memory_1_empty,
    output logic [31:0] o_default_mem_1_base,
    output logic        o_write_finished,
    output logic        o_mem_we,
    output logic        o_mem_stb,
    output logic        o_mem_cyc,
    output logic [3:0]  o_mem_sel,
    output logic [31:0] o_mem_adr,
    output logic [31:0] o_mem_dat,
    input  logic [31:0] i_mem_dat,
    input  logic        i_mem_ack,
    input  logic        i_mem_int,
    input  logic        i_ppfifo_rdy,
    output logic        o_ppfifo_act,
    input  logic [23:0] i_ppfifo_size,
    output logic        o_ppfifo_stb,
    input  logic [31:0] i_ppfifo_data
);

    state_e      state_q, state_d;
    logic        act_q, act_d;
    logic        cyc_q, cyc_d;
    logic        stb_q, stb_d;
    logic        we_q, we_d;
    logic [3:0]  sel_q, sel_d;
    logic [31:0] adr_q, adr_d;
    logic [31:0] dat_q, dat_d;
    logic        pp_stb_q, pp_stb_d;
    logic [23:0] blk_size_q, blk_size_d;
    logic [23:0] idx_q, idx_d;
    logic        cur_q, cur_d;
    logic        next_q, next_d;

    logic        inc_0, inc_1;
    logic [31:0] base_0, base_1, size_0, size_1;
    logic [31:0] cur_base, cur_size, cur_count;
    logic        unused_inputs;

    ppfifo_2_mem_buf_ctrl u_buf_0 (
        .clk(clk), .rst(rst),
        .i_base(i_memory_0_base), .i_size(i_memory_0_size),
        .i_ready(i_memory_0_ready), .i_inc(inc_0),
        .o_base(base_0), .o_size(size_0), .o_count(o_memory_0_count),
        .o_empty(o_memory_0_empty), .o_finished(o_memory_0_finished)
    );

    ppfifo_2_mem_buf_ctrl u_buf_1 (
        .clk(clk), .rst(rst),
        .i_base(i_memory_1_base), .i_size(i_memory_1_size),
        .i_ready(i_memory_1_ready), .i_inc(inc_1),
        .o_base(base_1), .o_size(size_1), .o_count(o_memory_1_count),
        .o_empty(o_memory_1_empty), .o_finished(o_memory_1_finished)
    );

    assign cur_base  = cur_q ? base_1 : base_0;
    assign cur_size  = cur_q ? size_1 : size_0;
    assign cur_count = cur_q ? o_memory_1_count : o_memory_0_count;

    always_comb begin
        state_d    = state_q;
        act_d      = act_q;
        cyc_d      = cyc_q;
        stb_d      = stb_q;
        we_d       = we_q;
        sel_d      = sel_q;
        adr_d      = adr_q;
        dat_d      = dat_q;
        pp_stb_d   = 1'b0;
        blk_size_d = blk_size_q;
        idx_d      = idx_q;
        cur_d      = cur_q;
        next_d     = next_q;
        inc_0      = 1'b0;
        inc_1      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (i_enable && i_ppfifo_rdy && (!o_memory_0_empty || !o_memory_1_empty)) begin
                    act_d      = 1'b1;
                    blk_size_d = i_ppfifo_size;
                    idx_d      = 24'd0;
                    state_d    = ST_ACTIVATE;
                end
            end
            ST_ACTIVATE: begin
                if (blk_size_q == 24'd0) begin
                    act_d   = 1'b0;
                    cyc_d   = 1'b0;
                    state_d = ST_RELEASE;
                end else begin
                    state_d = ST_NEXT;
                end
            end
            ST_NEXT: begin
                if (idx_q == blk_size_q) begin
                    act_d   = 1'b0;
                    cyc_d   = 1'b0;
                    state_d = ST_RELEASE;
                end else if (!o_memory_0_empty || !o_memory_1_empty) begin
                    // Remember the chosen buffer so it is kept until it fills.
                    cur_d   = pick_buf(next_q, o_memory_0_empty, o_memory_1_empty);
                    next_d  = cur_d;
                    state_d = ST_WRITE;
                end
            end
            ST_WRITE: begin
                cyc_d   = 1'b1;
                stb_d   = 1'b1;
                we_d    = 1'b1;
                sel_d   = SEL_ALL;
                adr_d   = cur_base + cur_count;
                dat_d   = i_ppfifo_data;
                state_d = ST_WAIT_ACK;
            end
            ST_WAIT_ACK: begin
                if (i_mem_ack) begin
                    stb_d    = 1'b0;
                    we_d     = 1'b0;
                    sel_d    = 4'h0;
                    pp_stb_d = 1'b1;
                    idx_d    = idx_q + 24'd1;
                    inc_0    = ~cur_q;
                    inc_1    = cur_q;
                    if ((cur_count + 32'd1) == cur_size) begin
                        next_d = ~cur_q;
                    end
                    state_d = ST_NEXT;
                end
            end
            ST_RELEASE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            act_q      <= 1'b0;
            cyc_q      <= 1'b0;
            stb_q      <= 1'b0;
            we_q       <= 1'b0;
            sel_q      <= 4'h0;
            adr_q      <= 32'd0;
            dat_q      <= 32'd0;
            pp_stb_q   <= 1'b0;
            blk_size_q <= 24'd0;
            idx_q      <= 24'd0;
            cur_q      <= 1'b0;
            next_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            act_q      <= act_d;
            cyc_q      <= cyc_d;
            stb_q      <= stb_d;
            we_q       <= we_d;
            sel_q      <= sel_d;
            adr_q      <= adr_d;
            dat_q      <= dat_d;
            pp_stb_q   <= pp_stb_d;
            blk_size_q <= blk_size_d;
            idx_q      <= idx_d;
            cur_q      <= cur_d;
            next_q     <= next_d;
        end
    end

    assign o_ppfifo_act         = act_q;
    assign o_ppfifo_stb         = pp_stb_q;
    assign o_mem_cyc            = cyc_q;
    assign o_mem_stb            = stb_q;
    assign o_mem_we             = we_q;
    assign o_mem_sel            = sel_q;
    assign o_mem_adr            = adr_q;
    assign o_mem_dat            = dat_q;
    assign o_write_finished     = o_memory_0_finished | o_memory_1_finished;
    assign o_default_mem_0_base = DEFAULT_MEM_0_BASE;
    assign o_default_mem_1_base = DEFAULT_MEM_1_BASE;

    // Write-only master: read data and interrupt are not used.
    assign unused_inputs = ^{i_mem_dat, i_mem_int};

`ifdef PPFIFO_2_MEM_DEBUG_EN
    assign debug = {state_q, cur_q, o_memory_1_empty, o_memory_0_empty, act_q, idx_q};
`else
    assign debug = 32'd0;
`endif

endmodule

// File: tb/tb_wb_ppfifo_to_mem.sv
`timescale 1ns/1ps
module tb_wb_ppfifo_to_mem;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] debug;
    logic        i_enable = 1'b1;
    logic [31:0] i_memory_0_base = '0, i_memory_0_size = '0, o_memory_0_count;
    logic        i_memory_0_ready = 1'b0, o_memory_0_finished, o_memory_0_empty;
    logic [31:0] o_default_mem_0_base;
    logic [31:0] i_memory_1_base = '0, i_memory_1_size = '0, o_memory_1_count;
    logic        i_memory_1_ready = 1'b0, o_memory_1_finished, o_memory_1_empty;
    logic [31:0] o_default_mem_1_base;
    logic        o_write_finished, o_mem_we, o_mem_stb, o_mem_cyc;
    logic [3:0]  o_mem_sel;
    logic [31:0] o_mem_adr, o_mem_dat;
    logic [31:0] i_mem_dat = '0;
    logic        i_mem_ack = 1'b0;
    logic        i_mem_int = 1'b0;
    logic        i_ppfifo_rdy = 1'b0, o_ppfifo_act, o_ppfifo_stb;
    logic [23:0] i_ppfifo_size = '0;
    logic [31:0] i_ppfifo_data;

    always #5 clk = ~clk;

    wb_ppfifo_to_mem dut (
        .clk(clk), .rst(rst), .debug(debug), .i_enable(i_enable),
        .i_memory_0_base(i_memory_0_base), .i_memory_0_size(i_memory_0_size),
        .o_memory_0_count(o_memory_0_count), .i_memory_0_ready(i_memory_0_ready),
        .o_memory_0_finished(o_memory_0_finished), .o_memory_0_empty(o_memory_0_empty),
        .o_default_mem_0_base(o_default_mem_0_base),
        .i_memory_1_base(i_memory_1_base), .i_memory_1_size(i_memory_1_size),
        .o_memory_1_count(o_memory_1_count), .i_memory_1_ready(i_memory_1_ready),
        .o_memory_1_finished(o_memory_1_finished), .o_memory_1_empty(o_memory_1_empty),
        .o_default_mem_1_base(o_default_mem_1_base),
        .o_write_finished(o_write_finished),
        .o_mem_we(o_mem_we), .o_mem_stb(o_mem_stb), .o_mem_cyc(o_mem_cyc),
        .o_mem_sel(o_mem_sel), .o_mem_adr(o_mem_adr), .o_mem_dat(o_mem_dat),
        .i_mem_dat(i_mem_dat), .i_mem_ack(i_mem_ack), .i_mem_int(i_mem_int),
        .i_ppfifo_rdy(i_ppfifo_rdy), .o_ppfifo_act(o_ppfifo_act),
        .i_ppfifo_size(i_ppfifo_size), .o_ppfifo_stb(o_ppfifo_stb),
        .i_ppfifo_data(i_ppfifo_data)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Reference model: buffers described by what the host armed and how
    // many words have landed in each.
    logic [31:0] m_base [2];
    logic [31:0] m_size [2];
    logic [31:0] m_count[2];
    bit          m_armed[2];
    int          m_next;
    int          m_fin  [2];

    logic [31:0] blk [256];
    int          blk_len  = 0;
    int          word_idx = 0;
    int          fifo_ptr = 0;
    int          ack_wait = 0;
    int          fin_seen [2];
    int          wfin_seen = 0;
    int          act_rises = 0;
    bit          act_prev  = 0;

    assign i_ppfifo_data = blk[fifo_ptr[7:0]];

    task automatic model_reset();
        for (int b = 0; b < 2; b++) begin
            m_base[b] = '0; m_size[b] = '0; m_count[b] = '0; m_armed[b] = 0;
            m_fin[b] = 0; fin_seen[b] = 0;
        end
        m_next = 0; wfin_seen = 0;
    endtask

    // One word acknowledged: where should it have gone?
    task automatic model_write();
        int b;
        b = m_armed[m_next] ? m_next : 1 - m_next;
        check("armed_on_write", {31'd0, m_armed[b]}, 32'd1);
        check("adr", o_mem_adr, m_base[b] + m_count[b]);
        check("dat", o_mem_dat, blk[word_idx[7:0]]);
        check("we_sel_cyc", {27'd0, o_mem_cyc, o_mem_we, o_mem_sel}, 32'h3F);
        word_idx++;
        m_next = b;
        m_count[b] = m_count[b] + 32'd1;
        if (m_count[b] == m_size[b]) begin
            m_armed[b] = 0;
            m_fin[b]++;
            m_next = 1 - b;
        end
    endtask

    // Wishbone slave with random ack latency, FIFO pointer, pulse monitors.
    always @(negedge clk) begin
        if (rst) begin
            i_mem_ack = 1'b0;
        end else if (o_mem_stb && !i_mem_ack) begin
            if (ack_wait == 0) begin
                i_mem_ack = 1'b1;
                model_write();
                ack_wait = $urandom_range(0, 2);
            end else begin
                ack_wait--;
            end
        end else begin
            i_mem_ack = 1'b0;
        end
        if (o_ppfifo_stb) fifo_ptr++;
        if (o_memory_0_finished) fin_seen[0]++;
        if (o_memory_1_finished) fin_seen[1]++;
        if (o_write_finished) wfin_seen++;
        if (o_ppfifo_act && !act_prev) act_rises++;
        act_prev = o_ppfifo_act;
    end

    task automatic arm(input int b, input logic [31:0] base, input logic [31:0] size);
        @(negedge clk);
        if (b == 0) begin
            i_memory_0_base = base; i_memory_0_size = size; i_memory_0_ready = 1'b1;
        end else begin
            i_memory_1_base = base; i_memory_1_size = size; i_memory_1_ready = 1'b1;
        end
        if (!m_armed[b] && size != 32'd0) begin
            m_armed[b] = 1; m_base[b] = base; m_size[b] = size; m_count[b] = '0;
        end
        @(negedge clk);
        i_memory_0_ready = 1'b0;
        i_memory_1_ready = 1'b0;
    endtask

    task automatic start_block(input int len);
        for (int i = 0; i < len; i++) blk[i] = $urandom;
        blk_len = len; word_idx = 0; fifo_ptr = 0;
        i_ppfifo_size = 24'(len);
        i_ppfifo_rdy  = 1'b1;
    endtask

    task automatic wait_act(input string tag);
        int t = 0;
        while (!o_ppfifo_act && t < 200) begin @(negedge clk); t++; end
        check({tag, " act_rise"}, {31'd0, o_ppfifo_act}, 32'd1);
        i_ppfifo_rdy = 1'b0;
    endtask

    task automatic finish_block(input string tag, input bit auto_arm);
        int t = 0;
        while (o_ppfifo_act && t < 3000) begin
            if (auto_arm && o_memory_0_empty && o_memory_1_empty && word_idx < blk_len)
                arm($urandom_range(0, 1), $urandom, $urandom_range(1, 6));
            else
                @(negedge clk);
            t++;
        end
        check({tag, " act_done"}, {31'd0, o_ppfifo_act}, 32'd0);
        check({tag, " words"}, word_idx, blk_len);
    endtask

    task automatic check_state(input string tag);
        check({tag, " count0"}, o_memory_0_count, m_count[0]);
        check({tag, " count1"}, o_memory_1_count, m_count[1]);
        check({tag, " empty0"}, {31'd0, o_memory_0_empty}, {31'd0, !m_armed[0]});
        check({tag, " empty1"}, {31'd0, o_memory_1_empty}, {31'd0, !m_armed[1]});
        check({tag, " fin0"}, fin_seen[0], m_fin[0]);
        check({tag, " fin1"}, fin_seen[1], m_fin[1]);
        check({tag, " wfin"}, wfin_seen, m_fin[0] + m_fin[1]);
    endtask

    initial begin
        int rises0;
        int t;
        model_reset();
        repeat (3) @(negedge clk);
        check("rst empty0", {31'd0, o_memory_0_empty}, 32'd1);
        check("rst empty1", {31'd0, o_memory_1_empty}, 32'd1);
        check("rst count0", o_memory_0_count, 32'd0);
        check("rst count1", o_memory_1_count, 32'd0);
        check("rst defbase0", o_default_mem_0_base, 32'h0000_0000);
        check("rst defbase1", o_default_mem_1_base, 32'h0010_0000);
        check("rst cyc_act_stb", {29'd0, o_mem_cyc, o_ppfifo_act, o_mem_stb}, 32'd0);
        check("rst wfin", {31'd0, o_write_finished}, 32'd0);
`ifndef PPFIFO_2_MEM_DEBUG_EN
        check("rst debug", debug, 32'd0);
`endif
        rst = 1'b0;
        @(negedge clk);

        // Single buffer, block exactly fills it.
        arm(0, 32'h100, 32'd4);
        check("arm0 empty0", {31'd0, o_memory_0_empty}, 32'd0);
        start_block(4);
        for (int i = 0; i < 4; i++) blk[i] = 32'hA + 32'(i);
        wait_act("one");
        finish_block("one", 0);
        check_state("one");
        check("one count0_abs", o_memory_0_count, 32'd4);

        // Both armed, one block spans both buffers in a single act window.
        arm(0, 32'h300, 32'd3);
        arm(1, 32'h200, 32'd3);
        rises0 = act_rises;
        start_block(6);
        wait_act("two");
        finish_block("two", 0);
        check_state("two");
        check("two act_windows", act_rises - rises0, 32'd1);

        // Only buffer 0 armed: stall after 2 words until buffer 1 is armed.
        arm(0, 32'h400, 32'd2);
        start_block(4);
        wait_act("stall");
        t = 0;
        while (word_idx < 2 && t < 500) begin @(negedge clk); t++; end
        repeat (10) @(negedge clk);
        check("stall words", word_idx, 32'd2);
        check("stall act_stb", {30'd0, o_ppfifo_act, o_mem_stb}, 32'd2);
        check("stall empty0", {31'd0, o_memory_0_empty}, 32'd1);
        arm(1, 32'h500, 32'd8);
        finish_block("stall", 0);
        check_state("stall");

        // Ignored arms: size 0 on an empty buffer, any arm on a busy buffer.
        arm(0, 32'h700, 32'd0);
        check("ign size0 empty0", {31'd0, o_memory_0_empty}, 32'd1);
        arm(1, 32'h800, 32'd5);
        check("ign busy empty1", {31'd0, o_memory_1_empty}, 32'd0);
        check("ign busy count1", o_memory_1_count, 32'd2);

        // Enable gating.
        i_enable = 1'b0;
        rises0 = act_rises;
        start_block(4);
        repeat (20) @(negedge clk);
        check("en_off no_act", act_rises - rises0, 32'd0);
        i_enable = 1'b1;
        wait_act("en_mid");
        t = 0;
        while (word_idx < 1 && t < 500) begin @(negedge clk); t++; end
        i_enable = 1'b0;
        finish_block("en_mid", 1);
        check_state("en_mid");
        rises0 = act_rises;
        start_block(3);
        repeat (20) @(negedge clk);
        check("en_off2 no_act", act_rises - rises0, 32'd0);
        i_enable = 1'b1;
        wait_act("en_on");
        finish_block("en_on", 1);
        check_state("en_on");

        // Randomized blocks and buffer sizes, including an address wrap.
        for (int it = 0; it < 14; it++) begin
            if (it == 0 && !m_armed[0]) arm(0, 32'hFFFF_FFFE, 32'd4);
            for (int b = 0; b < 2; b++)
                if (!m_armed[b] && $urandom_range(0, 1) == 1)
                    arm(b, $urandom, $urandom_range(1, 6));
            if (!m_armed[0] && !m_armed[1]) arm(0, $urandom, $urandom_range(1, 6));
            start_block($urandom_range(0, 10));
            wait_act("rnd");
            finish_block("rnd", 1);
            check_state("rnd");
        end

        // Asynchronous reset in the middle of a transfer.
        if (!m_armed[0] && !m_armed[1]) arm(0, 32'h900, 32'd8);
        start_block(8);
        wait_act("arst");
        t = 0;
        while (!(o_mem_stb && word_idx >= 2) && t < 500) begin @(negedge clk); t++; end
        check("arst reached", {31'd0, o_mem_stb}, 32'd1);
        #2 rst = 1'b1;
        #1;
        check("arst cyc_stb_act", {29'd0, o_mem_cyc, o_mem_stb, o_ppfifo_act}, 32'd0);
        check("arst empties", {30'd0, o_memory_1_empty, o_memory_0_empty}, 32'd3);
        repeat (2) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
